// File: rtl/pwpoly_pkg.sv
// Shared types and field helpers for the piecewise-polynomial activation controller.
// Holds FSM encoding, IEEE-754 single field positions and address-width helpers.
package pwpoly_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MANT_HI  = 22;
  localparam int MANT_W   = 23;

  localparam int DEF_E_MIN  = 126;
  localparam int DEF_NBANDS = 5;

  function automatic int seg_w(input int nbands);
    return nbands + 1;
  endfunction

  function automatic int k_w(input int degree);
    return (degree < 1) ? 1 : $clog2(degree + 1);
  endfunction

  // ROM address layout is {func, sign, seg, k}
  function automatic int addr_w(input int func_bits, input int nbands, input int degree);
    return func_bits + 1 + seg_w(nbands) + k_w(degree);
  endfunction

endpackage

// File: rtl/pwpoly_seg_decode.sv
// Combinational segment decode: exponent band plus leading mantissa bits select the segment.
// Below the first band maps to segment 0; above the last band (and Inf/NaN) maps to SAT.
module pwpoly_seg_decode
  import pwpoly_pkg::*;
#(
  parameter int E_MIN  = DEF_E_MIN,
  parameter int NBANDS = DEF_NBANDS
) (
  input  logic [30:0]     x,
  output logic [NBANDS:0] seg,
  output logic            sat
);

  localparam int SW = NBANDS + 1;

  logic [7:0]        e;
  logic [MANT_HI:0]  m;
  int                b;

  always_comb begin
    e   = x[EXP_HI:EXP_LO];
    m   = x[MANT_HI:0];
    b   = int'(e) - E_MIN;
    seg = '0;
    sat = 1'b0;
    if (int'(e) < E_MIN) begin
      seg = '0;
    end else if (b < NBANDS) begin
      // band b splits into 2^b segments using the top b mantissa bits
      seg = (SW'(1) << b) | SW'(m >> (MANT_W - b));
    end else begin
      seg = SW'(1) << NBANDS;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/pwpoly_act_ctrl.sv
// Horner-scheme activation sequencer driving a coefficient ROM and an external FMA.
// One operand in flight; in_ready only in IDLE, FMA and output stall on their ready inputs.
module pwpoly_act_ctrl
  import pwpoly_pkg::*;
#(
  parameter int DEGREE    = 3,
  parameter int FUNC_BITS = 1,
  parameter int E_MIN     = DEF_E_MIN,
  parameter int NBANDS    = DEF_NBANDS,
  parameter int FMA_LAT   = 2
) (
  input  logic                                        clk,
  input  logic                                        res,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [31:0]                                 in_x,
  input  logic [FUNC_BITS-1:0]                        in_func,
  output logic                                        coef_rd,
  output logic [addr_w(FUNC_BITS, NBANDS, DEGREE)-1:0] coef_addr,
  input  logic [31:0]                                 coef_data,
  output logic                                        fma_valid,
  input  logic                                        fma_ready,
  output logic [31:0]                                 fma_a,
  output logic [31:0]                                 fma_b,
  output logic [31:0]                                 fma_c,
  input  logic                                        fma_done,
  input  logic [31:0]                                 fma_result,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [31:0]                                 out_y
);

  localparam int KW = k_w(DEGREE);
  localparam int SW = seg_w(NBANDS);

  if (DEGREE < 1 || DEGREE > 7 || NBANDS < 1 || NBANDS > 6 || FMA_LAT < 1) begin : g_bad_param
    $error("pwpoly_act_ctrl: parameter out of legal range");
  end

  state_t               state, nstate;
  logic [31:0]          x_q, acc, creg;
  logic [FUNC_BITS-1:0] func_q;
  logic [SW-1:0]        seg_q, seg_d;
  logic                 sat_q, sat_d;
  logic                 first_q;
  logic [KW-1:0]        k_q;

  pwpoly_seg_decode #(
    .E_MIN  (E_MIN),
    .NBANDS (NBANDS)
  ) u_seg (
    .x   (in_x[30:0]),
    .seg (seg_d),
    .sat (sat_d)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    coef_rd   = 1'b0;
    fma_valid = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = S_FETCH;
      end
      S_FETCH: begin
        coef_rd = 1'b1;
        nstate  = S_LOAD;
      end
      S_LOAD: begin
        // DEGREE >= 1, so the leading coefficient alone never completes a normal operand
        if (first_q) nstate = sat_q ? S_DONE : S_FETCH;
        else         nstate = S_ISSUE;
      end
      S_ISSUE: begin
        fma_valid = 1'b1;
        if (fma_ready) nstate = S_WAIT;
      end
      S_WAIT: begin
        if (fma_done) nstate = (k_q == '0) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      x_q     <= '0;
      func_q  <= '0;
      seg_q   <= '0;
      sat_q   <= 1'b0;
      first_q <= 1'b0;
      k_q     <= '0;
      acc     <= '0;
      creg    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_q     <= in_x;
            func_q  <= in_func;
            seg_q   <= seg_d;
            sat_q   <= sat_d;
            first_q <= 1'b1;
            k_q     <= sat_d ? '0 : KW'(DEGREE);
          end
        end
        S_LOAD: begin
          if (first_q) begin
            acc     <= coef_data;
            first_q <= 1'b0;
            if (!sat_q) k_q <= k_q - KW'(1);
          end else begin
            creg <= coef_data;
          end
        end
        S_WAIT: begin
          if (fma_done) begin
            acc <= fma_result;
            if (k_q != '0) k_q <= k_q - KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign coef_addr = {func_q, x_q[SIGN_BIT], seg_q, k_q};
  assign fma_a     = acc;
  assign fma_b     = x_q;
  assign fma_c     = creg;
  assign out_y     = acc;

endmodule

// File: tb/tb_pwpoly_act_ctrl.sv
// Directed bench for pwpoly_act_ctrl with a behavioural ROM and a fixed-latency FMA.
// The stand-in FMA uses modular 32-bit integer a*b+c so the Horner reference is exact.
module tb_pwpoly_act_ctrl;

  localparam int D  = 3;
  localparam int FB = 1;
  localparam int EM = 126;
  localparam int NB = 5;
  localparam int FL = 2;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          res;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_x;
  logic [FB-1:0] in_func;
  logic          coef_rd;
  logic [AW-1:0] coef_addr;
  logic [31:0]   coef_data;
  logic          fma_valid;
  logic          fma_ready;
  logic [31:0]   fma_a, fma_b, fma_c;
  logic          fma_done;
  logic [31:0]   fma_result;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;

  int checks = 0;
  int errors = 0;

  pwpoly_act_ctrl #(
    .DEGREE(D), .FUNC_BITS(FB), .E_MIN(EM), .NBANDS(NB), .FMA_LAT(FL)
  ) dut (
    .clk(clk), .res(res),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_func(in_func),
    .coef_rd(coef_rd), .coef_addr(coef_addr), .coef_data(coef_data),
    .fma_valid(fma_valid), .fma_ready(fma_ready),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_done(fma_done), .fma_result(fma_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    return 32'hA500_0000 | (32'(a) << 8) | 32'h17;
  endfunction

  always @(posedge clk) coef_data <= coef_rd ? rom(coef_addr) : 32'hBAD0_BAD0;

  // FMA is not tied to res: a request in flight at reset still returns its strobe
  logic [FL-1:0] done_sr = '0;
  logic [31:0]   res_sr [FL];
  always @(posedge clk) begin
    done_sr   <= {done_sr[FL-2:0], fma_valid && fma_ready};
    res_sr[0] <= fma_a * fma_b + fma_c;
    for (int i = 1; i < FL; i++) res_sr[i] <= res_sr[i-1];
  end
  assign fma_done   = done_sr[FL-1];
  assign fma_result = res_sr[FL-1];

  logic [AW-1:0] rd_log[$];
  always @(posedge clk) if (coef_rd) rd_log.push_back(coef_addr);

  typedef struct {
    logic [31:0]   x;
    logic [FB-1:0] f;
    logic [5:0]    seg;
    logic          sat;
    int            lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input vec_t v, input int k);
    return {v.f, v.x[31], v.seg, 2'(k)};
  endfunction

  function automatic logic [31:0] horner(input vec_t v);
    logic [31:0] acc;
    if (v.sat) return rom(addr_of(v, 0));
    acc = rom(addr_of(v, D));
    for (int k = D - 1; k >= 0; k--) acc = acc * v.x + rom(addr_of(v, k));
    return acc;
  endfunction

  // stall_step: which FMA request (1-based) sees fma_ready low for 4 cycles, 0 = none
  task automatic run_vec(input vec_t v, input int stall_step, input int out_hold, input string tag);
    int          lat, n, issue_idx, stall_left, nrd;
    logic        prev_fv, bad_rdy, bad_stall, bad_hold;
    logic [31:0] sa, sb, sc, y, y_hold;
    rd_log.delete();
    @(negedge clk);
    in_x = v.x; in_func = v.f; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; issue_idx = 0; stall_left = 0; prev_fv = 1'b0;
    bad_rdy = 1'b0; bad_stall = 1'b0; sa = '0; sb = '0; sc = '0;
    while (!out_valid && lat < 200) begin
      if (in_ready) bad_rdy = 1'b1;
      if (fma_valid && !prev_fv) begin
        issue_idx++;
        if (issue_idx == stall_step) begin
          fma_ready = 1'b0; stall_left = 4;
          sa = fma_a; sb = fma_b; sc = fma_c;
        end
      end else if (stall_left > 0) begin
        if (!fma_valid || fma_a !== sa || fma_b !== sb || fma_c !== sc) bad_stall = 1'b1;
        stall_left--;
        if (stall_left == 0) fma_ready = 1'b1;
      end
      prev_fv = fma_valid;
      @(posedge clk); #1;
      lat++;
    end
    fma_ready = 1'b1;
    y = horner(v);
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " out_y"}, out_y, y);
    chk({tag, " in_ready in DONE"}, {31'd0, in_ready}, 32'd0);
    chk({tag, " in_ready busy"}, {31'd0, bad_rdy}, 32'd0);
    nrd = v.sat ? 1 : D + 1;
    chk({tag, " read count"}, 32'(rd_log.size()), 32'(nrd));
    for (int i = 0; i < rd_log.size() && i < nrd; i++)
      chk($sformatf("%s read %0d addr", tag, i), 32'(rd_log[i]), 32'(addr_of(v, v.sat ? 0 : D - i)));
    if (stall_step > 0) chk({tag, " fma operands stable"}, {31'd0, bad_stall}, 32'd0);
    y_hold = out_y; bad_hold = 1'b0;
    for (int i = 0; i < out_hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_y !== y_hold || in_ready) bad_hold = 1'b1;
    end
    if (out_hold > 0) chk({tag, " output hold"}, {31'd0, bad_hold}, 32'd0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, " out_valid after hs"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " in_ready after hs"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          x             f     seg    sat   lat
    vecs[0] = '{32'h0000_0000, 1'b0, 6'd0,  1'b0, 18};  // +0.0, below bands
    vecs[1] = '{32'hC0A0_0000, 1'b0, 6'd10, 1'b0, 18};  // -5.0, band 3
    vecs[2] = '{32'h4180_0000, 1'b0, 6'd32, 1'b1, 3};   // 16.0, above bands
    vecs[3] = '{32'h7FC0_0000, 1'b1, 6'd32, 1'b1, 3};   // NaN
    vecs[4] = '{32'h3F00_0000, 1'b1, 6'd1,  1'b0, 18};  // 0.5, band 0
    vecs[5] = '{32'h3FC0_0000, 1'b0, 6'd3,  1'b0, 18};  // 1.5, band 1
    vecs[6] = '{32'h4170_0000, 1'b1, 6'd30, 1'b0, 18};  // 15.0, band 4
    vecs[7] = '{32'hBE80_0000, 1'b0, 6'd0,  1'b0, 18};  // -0.25
    vecs[8] = '{32'hFF80_0000, 1'b1, 6'd32, 1'b1, 3};   // -Inf

    res = 1'b0; in_valid = 1'b0; in_x = '0; in_func = '0;
    fma_ready = 1'b1; out_ready = 1'b0;
    #2 res = 1'b1;
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset coef_rd", {31'd0, coef_rd}, 32'd0);
    chk("reset fma_valid", {31'd0, fma_valid}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_y", out_y, 32'd0);
    chk("reset coef_addr", 32'(coef_addr), 32'd0);
    chk("reset fma_a", fma_a, 32'd0);
    chk("reset fma_b", fma_b, 32'd0);
    chk("reset fma_c", fma_c, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); res = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // FMA back-pressure on the second request: 4 extra cycles
    v = vecs[1]; v.f = 1'b1; v.lat = 22;
    run_vec(v, 2, 0, "fma stall");

    // consumer back-pressure for 5 cycles
    run_vec(vecs[6], 0, 5, "out hold");

    // reset while waiting on the first FMA result; its late strobe must be dropped
    rd_log.delete();
    @(negedge clk); in_x = vecs[1].x; in_func = vecs[1].f; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid busy in_ready", {31'd0, in_ready}, 32'd0);
    res = 1'b1;
    #1;
    chk("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid reset out_y", out_y, 32'd0);
    chk("mid reset coef_addr", 32'(coef_addr), 32'd0);
    chk("mid reset fma_b", fma_b, 32'd0);
    @(negedge clk); res = 1'b0;
    @(posedge clk); #1;
    chk("late fma_done present", {31'd0, fma_done}, 32'd1);
    @(posedge clk); #1;
    chk("late result dropped", out_y, 32'd0);
    chk("idle after late done", {31'd0, in_ready}, 32'd1);
    chk("no read after late done", {31'd0, coef_rd}, 32'd0);
    run_vec(vecs[5], 0, 0, "post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
